// File: rtl/regfile_dump_pkg.sv
// Shared constants and state encoding for the register-file dump sequencer.
// Width defaults match the 16 x 16-bit register file it reads from.
package regfile_dump_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_SEL_W  = 4;
   localparam int REG_COUNT = 2 ** RF_SEL_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Walks a range of register indices through one regfile read port and
// streams each captured value, tagged with its index, over valid/ready.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int SEL_W  = RF_SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  first,
   input  logic [SEL_W-1:0]  last,
   output logic              busy,
   output logic              done,
   output logic [SEL_W-1:0]  rf_sel,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_idx
);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [SEL_W-1:0]    last_q, last_d;
   logic [SEL_W-1:0]    out_idx_q, out_idx_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         out_idx_q  <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         out_idx_q  <= out_idx_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_d     = last_q;
      out_idx_d  = out_idx_q;
      out_data_d = out_data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d   = first;
               last_d  = last;
               state_d = ST_READ;
            end
         end
         // rf_sel has been stable on idx for a full cycle by this edge.
         ST_READ: begin
            out_data_d = rf_data;
            out_idx_d  = idx_q;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               if (idx_q == last_q) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + SEL_W'(1);
                  state_d = ST_READ;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // All outputs decode from registers only; nothing is combinational from inputs.
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign out_valid = (state_q == ST_SEND);
   assign rf_sel    = idx_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;

endmodule
